// File: rtl/load_tid_buffer_if.sv
// load_tid_buffer_if
// Groups the load-issue handshake and the cache response / writeback signals
// that connect the load unit and the data-cache port to load_tid_buffer.
//
// Parameters must match the load_tid_buffer instance they are bound to:
//   NR_ENTRIES  outstanding load slots; IW = max(1, clog2(NR_ENTRIES))
//   SB_ENTRIES  scoreboard depth;        TW = clog2(SB_ENTRIES)
//
// Signals (suffix shows direction as seen by the buffer):
//   alloc_valid_i     load unit issues a load
//   alloc_trans_id_i  scoreboard trans ID of that load       [TW]
//   alloc_ready_o     buffer can accept a load
//   alloc_idx_o       buffer index (cache transaction ID)     [IW]
//   rsp_valid_i       cache response valid
//   rsp_idx_i         buffer index carried by the response    [IW]
//   wb_valid_o        response forwarded to writeback
//   wb_trans_id_o     trans ID of the forwarded response      [TW]
//
// Modports: master = load unit / cache side, slave = load_tid_buffer.
interface load_tid_buffer_if #(
  parameter int NR_ENTRIES = 2,
  parameter int SB_ENTRIES = 8
);
  localparam int TW = $clog2(SB_ENTRIES);
  localparam int IW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  logic          alloc_valid_i;
  logic [TW-1:0] alloc_trans_id_i;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_idx_o;
  logic          rsp_valid_i;
  logic [IW-1:0] rsp_idx_i;
  logic          wb_valid_o;
  logic [TW-1:0] wb_trans_id_o;

  modport master (
    output alloc_valid_i, alloc_trans_id_i, rsp_valid_i, rsp_idx_i,
    input  alloc_ready_o, alloc_idx_o, wb_valid_o, wb_trans_id_o
  );

  modport slave (
    input  alloc_valid_i, alloc_trans_id_i, rsp_valid_i, rsp_idx_i,
    output alloc_ready_o, alloc_idx_o, wb_valid_o, wb_trans_id_o
  );
endinterface

// File: rtl/load_tid_buffer.sv
// load_tid_buffer
// Tracks outstanding loads between the load unit and the data-cache request
// port. Each issued load gets a buffer index (used as the cache transaction
// ID) and the entry remembers the scoreboard trans ID, which is handed back to
// writeback when the cache answers. A flush marks in-flight loads as killed so
// their late responses free the slot without reaching writeback.
//
// Parameters:
//   NR_ENTRIES  outstanding loads, 1..8
//   SB_ENTRIES  scoreboard depth (trans ID width TW = clog2(SB_ENTRIES))
//
// Ports:
//   clk_i        core clock
//   rst_ni       asynchronous active-low reset
//   flush_i      kill all in-flight loads
//   bus          load_tid_buffer_if.slave (alloc handshake, response, writeback)
//   occupancy_o  number of valid entries (killed entries included)
//   err_o        sticky: a response addressed an entry that was not in flight
//
// Build option:
//   LOAD_TID_BUFFER_BYPASS_EN  when defined, a slot freed by a response in the
//   current cycle may be handed out to a load in that same cycle. Otherwise a
//   freed slot becomes allocatable one cycle later.
module load_tid_buffer #(
  parameter int NR_ENTRIES = 2,
  parameter int SB_ENTRIES = 8,
  localparam int TW = $clog2(SB_ENTRIES),
  localparam int IW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  load_tid_buffer_if.slave bus,
  output logic [IW:0]     occupancy_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_KILLED = 2'd2
  } entry_state_e;

  logic [NR_ENTRIES-1:0] valid_vec;
  logic [NR_ENTRIES-1:0] killed_vec;
  logic [NR_ENTRIES-1:0] free_vec;
  logic [NR_ENTRIES-1:0] rsp_hit_vec;
  logic [TW-1:0]         tid_arr [NR_ENTRIES];

  logic          alloc_ready;
  logic          alloc_fire;
  logic [IW-1:0] alloc_idx;
  logic          sel_valid;
  logic          sel_killed;
  logic [TW-1:0] sel_tid;
  logic          err_reg;

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
    entry_state_e  state_reg, state_next;
    logic [TW-1:0] tid_reg, tid_next;
    logic          grant;

    assign rsp_hit_vec[gi] = bus.rsp_valid_i && (bus.rsp_idx_i == IW'(gi));
    assign valid_vec[gi]   = (state_reg != ST_FREE);
    assign killed_vec[gi]  = (state_reg == ST_KILLED);
    assign tid_arr[gi]     = tid_reg;
    assign grant           = alloc_fire && (alloc_idx == IW'(gi));

`ifdef LOAD_TID_BUFFER_BYPASS_EN
    assign free_vec[gi] = ~valid_vec[gi] | rsp_hit_vec[gi];
`else
    assign free_vec[gi] = ~valid_vec[gi];
`endif

    always_comb begin
      state_next = state_reg;
      tid_next   = tid_reg;
      case (state_reg)
        ST_FREE:   ;
        // A response in the flush cycle completes the load, so it wins over kill.
        ST_BUSY: begin
          if (rsp_hit_vec[gi])  state_next = ST_FREE;
          else if (flush_i)     state_next = ST_KILLED;
        end
        ST_KILLED: if (rsp_hit_vec[gi]) state_next = ST_FREE;
        default:   state_next = ST_FREE;
      endcase
      // Grants only ever target a free (or, with bypass, being-freed) slot,
      // so a new load overrides the release in the same cycle.
      if (grant) begin
        state_next = ST_BUSY;
        tid_next   = bus.alloc_trans_id_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg <= ST_FREE;
        tid_reg   <= '0;
      end else begin
        state_reg <= state_next;
        tid_reg   <= tid_next;
      end
    end
  end

  // Lowest-index free slot wins: scan downward so the last match is the lowest.
  always_comb begin
    alloc_idx = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
    end
  end

  // No new load may start while a flush is killing the in-flight ones.
  assign alloc_ready = (|free_vec) & ~flush_i;
  assign alloc_fire  = bus.alloc_valid_i & alloc_ready;

  // Explicit compare-select so an index beyond NR_ENTRIES-1 reads as invalid.
  always_comb begin
    sel_valid  = 1'b0;
    sel_killed = 1'b0;
    sel_tid    = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (bus.rsp_idx_i == IW'(i)) begin
        sel_valid  = valid_vec[i];
        sel_killed = killed_vec[i];
        sel_tid    = tid_arr[i];
      end
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      occupancy_o = occupancy_o + (IW + 1)'(valid_vec[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        err_reg <= 1'b0;
    else if (bus.rsp_valid_i && !sel_valid) err_reg <= 1'b1;
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_idx_o   = alloc_idx;
  assign bus.wb_valid_o    = bus.rsp_valid_i & sel_valid & ~sel_killed;
  assign bus.wb_trans_id_o = bus.wb_valid_o ? sel_tid : '0;
  assign err_o             = err_reg;

endmodule

// File: tb/tb_load_tid_buffer.sv
module tb_load_tid_buffer;
  localparam int NR = 2;
  localparam int SB = 8;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b1;
  logic       flush_i = 1'b0;
  logic [1:0] occupancy_o;
  logic       err_o;

  load_tid_buffer_if #(.NR_ENTRIES(NR), .SB_ENTRIES(SB)) bus ();

  load_tid_buffer #(.NR_ENTRIES(NR), .SB_ENTRIES(SB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .bus         (bus.slave),
    .occupancy_o (occupancy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [2:0] tid;
    string      tag;
  } wb_exp_t;
  wb_exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set all stimulus for the coming edge at the falling edge, settle 1 time unit.
  task automatic drive(input logic av, input logic [2:0] atid,
                       input logic rv, input logic ridx, input logic fl);
    @(negedge clk_i);
    bus.alloc_valid_i    = av;
    bus.alloc_trans_id_i = atid;
    bus.rsp_valid_i      = rv;
    bus.rsp_idx_i        = ridx;
    flush_i              = fl;
    #1;
    $display("t=%0t alloc_v=%0b tid=%0d rsp_v=%0b idx=%0d flush=%0b | rdy=%0b aidx=%0d wb_v=%0b wb_tid=%0d occ=%0d err=%0b",
             $time, av, atid, rv, ridx, fl, bus.alloc_ready_o, bus.alloc_idx_o,
             bus.wb_valid_o, bus.wb_trans_id_o, occupancy_o, err_o);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic [2:0] tid);
    wb_exp_t e;
    e.v = v; e.tid = tid; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_wb();
    wb_exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'(e.v));
      chk({e.tag, "_wb_tid"},   32'(bus.wb_trans_id_o), 32'(e.tid));
    end
  endtask

  initial begin
    bus.alloc_valid_i    = 1'b0;
    bus.alloc_trans_id_i = '0;
    bus.rsp_valid_i      = 1'b0;
    bus.rsp_idx_i        = '0;

    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("rst_occ",   32'(occupancy_o), 32'd0);
    chk("rst_wb",    32'(bus.wb_valid_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Back-to-back allocations fill the buffer
    drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("a0_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("a0_idx",   32'(bus.alloc_idx_o), 32'd0);
    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("a1_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("a1_idx",   32'(bus.alloc_idx_o), 32'd1);
    idle();
    chk("full_ready", 32'(bus.alloc_ready_o), 32'd0);
    chk("full_occ",   32'(occupancy_o), 32'd2);

    // Response to idx1, then reuse of that slot the next cycle
    expect_wb("rsp1", 1'b1, 3'd5);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_wb();
    chk("rsp1_occ", 32'(occupancy_o), 32'd2);
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("reuse_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("reuse_idx",   32'(bus.alloc_idx_o), 32'd1);
    idle();
    chk("reuse_occ", 32'(occupancy_o), 32'd2);

    // Flush kills both; late responses are dropped
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_ready", 32'(bus.alloc_ready_o), 32'd0);
    expect_wb("kill0", 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    check_wb();
    chk("kill0_occ", 32'(occupancy_o), 32'd2);
    expect_wb("kill1", 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_wb();
    chk("kill1_occ", 32'(occupancy_o), 32'd1);
    idle();
    chk("kill_occ_end", 32'(occupancy_o), 32'd0);
    chk("kill_err",     32'(err_o), 32'd0);

    // Flush + alloc + rsp in one cycle
    drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    expect_wb("flrsp0", 1'b1, 3'd3);
    drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
    check_wb();
    chk("flrsp_ready", 32'(bus.alloc_ready_o), 32'd0);
    idle();
    chk("flrsp_occ",   32'(occupancy_o), 32'd1);
    chk("flrsp_ready2", 32'(bus.alloc_ready_o), 32'd1);
    chk("flrsp_idx",   32'(bus.alloc_idx_o), 32'd0);
    expect_wb("flrsp1", 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_wb();
    idle();
    chk("flrsp_occ_end", 32'(occupancy_o), 32'd0);
    chk("flrsp_err",     32'(err_o), 32'd0);

    // Response to a free entry sets sticky error
    expect_wb("stray", 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_wb();
    idle();
    chk("err_set", 32'(err_o), 32'd1);
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    idle();
    chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_occ",    32'(occupancy_o), 32'd1);
    @(negedge clk_i) rst_ni = 1'b0;
    #1;
    chk("err_rst",     32'(err_o), 32'd0);
    chk("err_rst_occ", 32'(occupancy_o), 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Same-cycle reuse of a slot freed by a response
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    expect_wb("byp0", 1'b1, 3'd1);
    drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    check_wb();
`ifdef LOAD_TID_BUFFER_BYPASS_EN
    chk("byp_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("byp_idx",   32'(bus.alloc_idx_o), 32'd0);
    idle();
    chk("byp_occ", 32'(occupancy_o), 32'd2);
    expect_wb("byp_new", 1'b1, 3'd2);
    drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    check_wb();
`else
    chk("byp_ready", 32'(bus.alloc_ready_o), 32'd0);
    idle();
    chk("byp_occ", 32'(occupancy_o), 32'd1);
    chk("byp_ready2", 32'(bus.alloc_ready_o), 32'd1);
    chk("byp_idx2",   32'(bus.alloc_idx_o), 32'd0);
`endif

    // Reset mid-operation discards entries; a late response flags an error
    @(negedge clk_i) rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    expect_wb("post_rst", 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_wb();
    idle();
    chk("post_rst_err", 32'(err_o), 32'd1);
    chk("post_rst_occ", 32'(occupancy_o), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
